// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per clock, sliding 16-word schedule.
// Optional SHA-224 IV selection via `define SHA256_COMPRESS_SHA224_EN.
module prim_generic_maj #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    output logic [Width-1:0] maj_o
);
    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module sha256_compress (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    input  logic [511:0] block_i,
    input  logic         first_i,
`ifdef SHA256_COMPRESS_SHA224_EN
    input  logic         sha224_i,
`endif
    output logic [255:0] digest_o,
    output logic         digest_valid_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA256_COMPRESS_SHA224_EN
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        logic [63:0] y;
        y = {x, x} >> n;
        return y[31:0];
    endfunction

    state_e             state_q, state_d;
    logic [5:0]         t_q, t_d;
    // s_q[7] = a ... s_q[0] = h; w_q[15] always holds W[t]
    logic [7:0][31:0]   s_q, s_d;
    logic [7:0][31:0]   hc_q, hc_d;
    logic [7:0][31:0]   dig_q, dig_d;
    logic [15:0][31:0]  w_q, w_d;
    logic               dv_q, dv_d;

    logic [31:0] maj, ch, t1, t2, w_new, big_s0, big_s1, sm0, sm1;
    logic [255:0] iv;

    prim_generic_maj #(.Width(32)) u_maj (
        .a_i   (s_q[7]),
        .b_i   (s_q[6]),
        .c_i   (s_q[5]),
        .maj_o (maj)
    );

    assign big_s0 = rotr(s_q[7], 2) ^ rotr(s_q[7], 13) ^ rotr(s_q[7], 22);
    assign big_s1 = rotr(s_q[3], 6) ^ rotr(s_q[3], 11) ^ rotr(s_q[3], 25);
    assign ch     = (s_q[3] & s_q[2]) ^ (~s_q[3] & s_q[1]);
    assign t1     = s_q[0] + big_s1 + ch + K[t_q] + w_q[15];
    assign t2     = big_s0 + maj;

    assign sm0   = rotr(w_q[14], 7) ^ rotr(w_q[14], 18) ^ (w_q[14] >> 3);
    assign sm1   = rotr(w_q[1], 17) ^ rotr(w_q[1], 19) ^ (w_q[1] >> 10);
    assign w_new = sm1 + w_q[6] + sm0 + w_q[15];

`ifdef SHA256_COMPRESS_SHA224_EN
    assign iv = sha224_i ? IV224 : IV256;
`else
    assign iv = IV256;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        s_d     = s_q;
        hc_d    = hc_q;
        w_d     = w_q;
        dig_d   = dig_q;
        dv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (block_valid_i) begin
                    state_d = ROUND;
                    t_d     = 6'd0;
                    hc_d    = first_i ? iv : dig_q;
                    s_d     = first_i ? iv : dig_q;
                    w_d     = block_i;
                end
            end
            ROUND: begin
                s_d = {t1 + t2, s_q[7:5], s_q[4] + t1, s_q[3:1]};
                w_d = {w_q[14:0], w_new};
                t_d = t_q + 6'd1;
                if (t_q == 6'd63) state_d = FINAL;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) dig_d[i] = hc_q[i] + s_q[i];
                dv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            s_q     <= '0;
            hc_q    <= '0;
            w_q     <= '0;
            dig_q   <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            s_q     <= s_d;
            hc_q    <= hc_d;
            w_q     <= w_d;
            dig_q   <= dig_d;
            dv_q    <= dv_d;
        end
    end

    assign block_ready_o  = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign digest_o       = dig_q;
    assign digest_valid_o = dv_q;
endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress using known-answer digests.
// Build with +define+SHA256_COMPRESS_SHA224_EN to also cover SHA-224.
module tb_sha256_compress;
    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [511:0] blk;
    logic         first;
    logic [255:0] digest;
    logic         dv;
    logic         busy;
`ifdef SHA256_COMPRESS_SHA224_EN
    logic         sha224 = 1'b0;
`endif

    sha256_compress dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .block_valid_i  (valid),
        .block_ready_o  (ready),
        .block_i        (blk),
        .first_i        (first),
`ifdef SHA256_COMPRESS_SHA224_EN
        .sha224_i       (sha224),
`endif
        .digest_o       (digest),
        .digest_valid_o (dv),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [255:0] d;
        logic         en;
        logic         h224;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dv) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", 256'(dv), 256'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 256'(cyc - e.acc), 256'd65);
                if (e.h224)
                    chk("digest224", {digest[255:32], 32'h0}, {e.d[255:32], 32'h0});
                else if (e.en)
                    chk("digest", digest, e.d);
            end
        end
    end

    task automatic send(input logic [511:0] b, input logic f, input logic [255:0] d,
                        input logic en, input logic h224, input logic hold, output int acc);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("ready_timeout", 256'(ready), 256'd1);
        valid = 1'b1;
        blk   = b;
        first = f;
        @(posedge clk);
        #1;
        acc   = cyc;
        e.d   = d;
        e.en  = en;
        e.h224 = h224;
        e.acc = acc;
        q.push_back(e);
        if (!hold) valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 256'(q.size()), 256'd0);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, cnt;
        rst   = 1'b1;
        valid = 1'b0;
        blk   = '0;
        first = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_dv", 256'(dv), 256'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 256'(ready), 256'd1);
        chk("rst_digest", digest, 256'd0);

        send(ABC, 1'b1, D_ABC, 1'b1, 1'b0, 1'b0, a0);
        @(negedge clk);
        chk("busy_round", 256'(busy), 256'd1);
        drain();
        chk("digest_hold", digest, D_ABC);

        send(EMPTY, 1'b1, D_EMPTY, 1'b1, 1'b0, 1'b0, a0);
        drain();

        send(B1, 1'b1, '0, 1'b0, 1'b0, 1'b0, a0);
        send(B2, 1'b0, D_TWO, 1'b1, 1'b0, 1'b0, a1);
        chk("back_to_back", 256'(a1 - a0), 256'd66);
        drain();

        send(ABC, 1'b1, D_ABC, 1'b1, 1'b0, 1'b1, a0);
        blk   = ~ABC;
        first = 1'b0;
        cnt   = 0;
        @(negedge clk);
        while (!ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        valid = 1'b0;
        chk("ready_low_cycles", 256'(cnt), 256'd65);
        drain();

        send(ABC, 1'b1, D_ABC, 1'b1, 1'b0, 1'b0, a0);
        repeat (31) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_digest", digest, 256'd0);
        chk("abort_ready", 256'(ready), 256'd1);
        chk("abort_busy", 256'(busy), 256'd0);
        repeat (80) @(negedge clk);
        send(ABC, 1'b1, D_ABC, 1'b1, 1'b0, 1'b0, a0);
        drain();

`ifdef SHA256_COMPRESS_SHA224_EN
        sha224 = 1'b1;
        send(ABC, 1'b1,
             256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000,
             1'b1, 1'b1, 1'b0, a0);
        drain();
        sha224 = 1'b0;
`endif

        chk("queue_empty", 256'(q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 Parameters: none; word width fixed at 32 bits, round count fixed at 64.
REQ-002 clk_i  input  1  single clock, all state on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 block_valid_i  input  1  512-bit message block offered.
REQ-005 block_ready_o  output  1  block accepted on the edge where block_valid_i and block_ready_o are both high.
REQ-006 block_i  input  512  padded block; W0 = block_i[511:480] ... W15 = block_i[31:0].
REQ-007 first_i  input  1  sampled at acceptance; 1 = chain from IV, 0 = chain from current digest register.
REQ-008 digest_o  output  256  digest register; H0 = [255:224] ... H7 = [31:0].
REQ-009 digest_valid_o  output  1  one-cycle pulse marking digest_o updated.
REQ-010 busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, ROUND and FINAL.
REQ-012 IDLE -> ROUND on acceptance: load a..h and the chaining register from IV or digest_o (per first_i), load W0..W15 into the 16-word schedule window, and clear the round counter.
REQ-013 ROUND: one round per cycle, t = 0..63; ROUND -> FINAL after t = 63.
REQ-014 FINAL: digest register = chaining word + working word, per word, mod 2^32; then -> IDLE.
REQ-015 digest_valid_o SHALL be high for exactly the cycle after the FINAL edge, i.e. the 66th cycle after the acceptance edge.
REQ-016 digest_o SHALL hold its value until the next FINAL or reset.
REQ-017 block_ready_o SHALL be high iff the state is IDLE; a new block can be accepted in the digest_valid_o cycle, giving 66 cycles per block.
REQ-018 block_i, first_i and block_valid_i SHALL be ignored outside IDLE.
REQ-019 Round arithmetic:
  - T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = S0(a) + Maj(a,b,c)
  - all additions mod 2^32; carries discarded.
REQ-020 Maj SHALL come from a prim_generic_maj instance (Width 32); Ch = (e&f)^(~e&g).
REQ-021 Rotations:
  - S0 = rotr2^rotr13^rotr22; S1 = rotr6^rotr11^rotr25
  - s0 = rotr7^rotr18^shr3; s1 = rotr17^rotr19^shr10.
REQ-022 Schedule for t >= 16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32, produced in the sliding window; no 64-word storage.
REQ-023 K[0..63] SHALL be the FIPS 180-4 constants, held in a combinational ROM indexed by the round counter.
REQ-024 SHA-256 IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.

Reset
REQ-025 While rst_i is high at an edge:
  - state = IDLE, round counter = 0
  - digest_o = 0, digest_valid_o = 0, busy_o = 0
  - working and schedule registers = 0.
REQ-026 block_ready_o SHALL be 1 in the first cycle after rst_i falls.
REQ-027 Reset during ROUND or FINAL SHALL abort the block with no digest_valid_o pulse.
REQ-028 A first_i = 0 block after reset SHALL chain from an all-zero digest.

Configuration
REQ-029 Macro SHA256_COMPRESS_SHA224_EN:
  - Defined: adds input port sha224_i (1 bit), sampled at acceptance. When first_i = 1 and sha224_i = 1, use the SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4. digest_o stays 256 bits; the consumer truncates to H0..H6.
  - Undefined: port absent; SHA-256 IV only.

Verification
REQ-030 "abc" block (61626380, 14 zero words, 00000018), first_i = 1 -> digest_valid_o exactly 66 cycles after acceptance; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-031 Empty-message block (80000000, 15 zero words), first_i = 1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 448-bit "abcdbcdecdefdefg...nopq" message as 2 blocks, first_i = 1 then 0, second block offered in the digest_valid_o cycle -> accepted immediately; final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 Block_valid_i held and block_i changed during ROUND -> block_ready_o = 0 for 65 cycles, the changed data is ignored, and the digest still matches REQ-030.
REQ-034 rst_i pulsed at round 30 of the "abc" block -> no pulse, digest_o = 0, ready next cycle; a re-run of "abc" matches REQ-030.
REQ-035 With SHA256_COMPRESS_SHA224_EN: "abc" with sha224_i = 1 -> H0..H6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
